ena_scheduler: RTL and testbench
================================

ENA_SCHEDULER -- requirements
Module: ena_scheduler

Interface
REQ-001 Parameter N, default 8: width of the enable vector (number of schedulable nets: inputs plus gates); legal range 2..64.
REQ-002 Parameter STALL_LIMIT, default 16: consecutive no-eligible cycles before deadlock is declared; legal range 1..255.
REQ-003 Parameter SEED, default 16'hACE1: LFSR reset value; SHALL be nonzero.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 run  input  1  level; 1 = free-running scheduling.
REQ-007 step  input  1  single-cycle pulse; requests exactly one fire while idle.
REQ-008 mode  input  1  0 = round-robin selection, 1 = pseudo-random selection.
REQ-009 mask  input  N  eligibility; bit i = 1 means net i is currently excited and may fire.
REQ-010 clear  input  1  pulse; leaves DEADLOCK.
REQ-011 ena  output  N  registered enable vector to the circuit model; one-hot or zero.
REQ-012 fired_idx  output  IW  index of the bit set in ena, IW = max(1, ceil(log2 N)); 0 when ena is zero.
REQ-013 fire_count  output  32  total fires since reset.
REQ-014 deadlock  output  1  high while in DEADLOCK.
REQ-015 busy  output  1  high in RUN or STEP.

Function
REQ-016 States: IDLE, RUN, STEP, DEADLOCK; state and all outputs registered, one-cycle latency from inputs to ena.
REQ-017 IDLE: run=1 -> RUN; else step=1 -> STEP; run takes priority over step in the same cycle.
REQ-018 RUN: run=0 -> IDLE at the next edge, and no fire is issued on that edge.
REQ-019 STEP: issues at most one fire, then -> IDLE; step pulses outside IDLE are ignored.
REQ-020 Each cycle in RUN/STEP, if mask != 0, exactly one eligible bit is selected and ena is set one-hot to it on the next edge; otherwise ena = 0.
REQ-021 Round-robin: search starts at pointer ptr and ascends with wrap N-1 -> 0; the first set mask bit wins; ptr <= winner+1 mod N.
REQ-022 Random: search starts at lfsr mod N, uses the same ascending wrap search, and does not update ptr.
REQ-023 LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in RUN/STEP, regardless of whether a fire occurs.
REQ-024 fire_count increments by 1 per fire, wraps 2^32-1 -> 0, and saturates in no other case.
REQ-025 Stall counter: increments per RUN/STEP cycle with mask = 0, clears on any fire or on leaving RUN/STEP.
REQ-026 When the stall counter reaches STALL_LIMIT -> DEADLOCK; STEP with mask = 0 waits in STEP and is also subject to this rule.
REQ-027 DEADLOCK: ena = 0 and run/step are ignored; clear=1 -> IDLE with the stall counter zeroed.
REQ-028 A mask change is sampled each cycle; a bit deasserted in cycle t is never fired at edge t+1.

Reset
REQ-029 reset=1 at any edge, including mid-RUN, forces IDLE and sets ena=0, fired_idx=0, fire_count=0, deadlock=0, busy=0, ptr=0, stall counter 0, lfsr=SEED.
REQ-030 reset overrides run, step and clear in the same cycle.

Configuration
REQ-031 Macro ENA_SCHEDULER_RANDOM_EN: when defined, the LFSR and mode=1 random selection are compiled in.
REQ-032 Without ENA_SCHEDULER_RANDOM_EN, no LFSR exists, the mode input is ignored, and selection is always round-robin.

Verification
REQ-033 N=8, mask=8'hFF, mode=0, run held 10 cycles -> ena = 01,02,04,...,80,01,02; fire_count=10.
REQ-034 mask=8'b0010_0100, mode=0, ptr=3, run -> fires idx 5, then 2, then 5; no other bits are ever set.
REQ-035 IDLE, step pulse with mask=8'h10 -> ena=8'h10 for exactly one cycle, then IDLE; busy high for 1 cycle.
REQ-036 run=1, mask=0, STALL_LIMIT=16 -> deadlock rises after 16 stall cycles; clear -> IDLE; fire_count unchanged.
REQ-037 Reset asserted during RUN after 5 fires -> next cycle ena=0, fire_count=0; the first fire after re-run is idx 0.
REQ-038 With ENA_SCHEDULER_RANDOM_EN, mode=1, mask=8'hFF, 1000 cycles -> each index fires >= 60 times and the sequence is identical across two runs from reset.

Source files
------------

// File: rtl/ena_scheduler.sv
// ena_scheduler: picks one excited net per cycle and drives a one-hot enable.
// Optional ENA_SCHEDULER_RANDOM_EN adds an LFSR for pseudo-random selection.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - synchronous active-high reset
//   run        - level, free-running scheduling
//   step       - pulse, one fire while idle
//   mode       - 0 round-robin, 1 pseudo-random (only with the macro)
//   mask [N]   - eligible nets
//   clear      - pulse, leaves DEADLOCK
//   ena [N]    - registered one-hot (or zero) enable
//   fired_idx  - index of the set bit in ena, 0 when ena is zero
//   fire_count - total fires since reset (wraps)
//   deadlock   - high while deadlocked
//   busy       - high in RUN or STEP
module ena_scheduler #(
    parameter int          N           = 8,
    parameter int          STALL_LIMIT = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int         IW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          step,
    input  logic          mode,
    input  logic [N-1:0]  mask,
    input  logic          clear,
    output logic [N-1:0]  ena,
    output logic [IW-1:0] fired_idx,
    output logic [31:0]   fire_count,
    output logic          deadlock,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DEAD
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [7:0]    stall_q, stall_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [N-1:0]  ena_q, ena_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          dead_q, dead_d;
    logic          busy_q, busy_d;

    logic          rnd_sel;
    logic [IW-1:0] start;
    logic          any;
    logic [IW-1:0] win;
    logic          active;

`ifdef ENA_SCHEDULER_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign rnd_sel = mode;
    assign start   = rnd_sel ? IW'({16'b0, lfsr_q} % 32'(N)) : ptr_q;
`else
    logic        unused_mode;
    logic [15:0] unused_seed;

    assign unused_mode = mode;
    assign unused_seed = SEED;
    assign rnd_sel     = 1'b0;
    assign start       = ptr_q;
`endif

    // First set mask bit at or above start, wrapping N-1 -> 0.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && mask[(int'(start) + i) % N]) begin
                any = 1'b1;
                win = IW'((int'(start) + i) % N);
            end
        end
    end

    // A RUN cycle with run low leaves without firing.
    assign active = (state_q == S_STEP) || (state_q == S_RUN && run);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        cnt_d   = cnt_q;
        ena_d   = '0;
        idx_d   = '0;
`ifdef ENA_SCHEDULER_RANDOM_EN
        lfsr_d  = lfsr_q;
        if (state_q == S_RUN || state_q == S_STEP) begin
            lfsr_d = {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
`endif
        unique case (state_q)
            S_IDLE: begin
                stall_d = '0;
                if (run) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end
            S_RUN, S_STEP: begin
                if (!active) begin
                    state_d = S_IDLE;
                    stall_d = '0;
                end else if (any) begin
                    ena_d[win] = 1'b1;
                    idx_d      = win;
                    cnt_d      = cnt_q + 32'd1;
                    stall_d    = '0;
                    if (!rnd_sel) begin
                        ptr_d = (int'(win) == N - 1) ? '0 : win + IW'(1);
                    end
                    if (state_q == S_STEP) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_d == 8'(STALL_LIMIT)) begin
                        state_d = S_DEAD;
                        stall_d = '0;
                    end
                end
            end
            S_DEAD: begin
                stall_d = '0;
                if (clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        dead_d = (state_d == S_DEAD);
        busy_d = (state_d == S_RUN) || (state_d == S_STEP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
            ena_q   <= '0;
            idx_q   <= '0;
            dead_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ENA_SCHEDULER_RANDOM_EN
            lfsr_q  <= SEED;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            idx_q   <= idx_d;
            dead_q  <= dead_d;
            busy_q  <= busy_d;
`ifdef ENA_SCHEDULER_RANDOM_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign ena        = ena_q;
    assign fired_idx  = idx_q;
    assign fire_count = cnt_q;
    assign deadlock   = dead_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ena_scheduler.sv
// tb_ena_scheduler: directed and randomized checks of ena_scheduler against
// a cycle-level behavioural model of the scheduling rules.
module tb_ena_scheduler;

    localparam int          N     = 8;
    localparam int          IW    = 3;
    localparam int          LIMIT = 16;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef ENA_SCHEDULER_RANDOM_EN
    localparam bit RAND = 1'b1;
`else
    localparam bit RAND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          mode = 1'b0;
    logic [N-1:0]  mask = '0;
    logic          clear = 1'b0;
    logic [N-1:0]  ena;
    logic [IW-1:0] fired_idx;
    logic [31:0]   fire_count;
    logic          deadlock;
    logic          busy;

    ena_scheduler #(.N(N), .STALL_LIMIT(LIMIT), .SEED(SEED)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .mode      (mode),
        .mask      (mask),
        .clear     (clear),
        .ena       (ena),
        .fired_idx (fired_idx),
        .fire_count(fire_count),
        .deadlock  (deadlock),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 run, 2 step, 3 deadlock.
    int          m_st;
    int          m_ptr;
    int          m_stall;
    logic [31:0] m_cnt;
    logic [15:0] m_lfsr;
    logic [N-1:0]  exp_ena;
    logic [IW-1:0] exp_idx;
    logic          exp_dl;
    logic          exp_busy;

    task automatic model_step();
        int  w;
        int  s;
        bit  act;
        w = -1;
        if (reset) begin
            m_st = 0; m_ptr = 0; m_stall = 0;
            m_cnt = 0; m_lfsr = SEED;
        end else begin
            case (m_st)
                0: if (run) m_st = 1; else if (step) m_st = 2;
                1, 2: begin
                    act = (m_st == 2) || run;
                    s = (RAND && mode) ? int'(m_lfsr) % N : m_ptr;
                    if (act && mask != 0) begin
                        for (int k = 0; k < N; k++)
                            if (w < 0 && mask[(s + k) % N]) w = (s + k) % N;
                        if (!(RAND && mode)) m_ptr = (w + 1) % N;
                        m_stall = 0;
                        m_cnt = m_cnt + 1;
                        if (m_st == 2) m_st = 0;
                    end else if (act) begin
                        m_stall++;
                        if (m_stall == LIMIT) begin
                            m_st = 3; m_stall = 0;
                        end
                    end else begin
                        m_st = 0; m_stall = 0;
                    end
                    m_lfsr = {m_lfsr[14:0],
                              m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                end
                default: if (clear) m_st = 0;
            endcase
        end
        exp_ena  = (w >= 0) ? N'(1) << w : '0;
        exp_idx  = (w >= 0) ? IW'(w) : '0;
        exp_dl   = (m_st == 3);
        exp_busy = (m_st == 1 || m_st == 2);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ena", 64'(ena), 64'(exp_ena));
            check("fired_idx", 64'(fired_idx), 64'(exp_idx));
            check("fire_count", 64'(fire_count), 64'(m_cnt));
            check("deadlock", 64'(deadlock), 64'(exp_dl));
            check("busy", 64'(busy), 64'(exp_busy));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

`ifdef ENA_SCHEDULER_RANDOM_EN
    logic [IW-1:0] seq1 [1000];
    int            hist [N];
    int            diffs;
`endif

    initial begin
        int k;
        cyc(2);
        chk_en = 1'b1;
        check("reset_ena", 64'(ena), 64'h0);
        check("reset_count", 64'(fire_count), 64'h0);
        reset = 1'b0;

        // Round-robin over a full mask, ten fires.
        mask = 8'hFF; mode = 1'b0; run = 1'b1;
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("rr_seq", 64'(ena), 64'(8'h01 << (i % 8)));
        end
        run = 1'b0;
        cyc(1);
        check("rr_count", 64'(fire_count), 64'd10);

        // Step moves ptr from 2 to 3.
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        check("step_idx2", 64'(fired_idx), 64'd2);

        // Sparse mask from ptr 3.
        mask = 8'b0010_0100; run = 1'b1;
        cyc(1);
        cyc(1); check("sparse_a", 64'(fired_idx), 64'd5);
        cyc(1); check("sparse_b", 64'(fired_idx), 64'd2);
        cyc(1); check("sparse_c", 64'(fired_idx), 64'd5);
        run = 1'b0;
        cyc(2);

        // Single step pulse.
        mask = 8'h10; step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("step_busy", 64'(busy), 64'd1);
        check("step_pre", 64'(ena), 64'h0);
        cyc(1);
        check("step_ena", 64'(ena), 64'h10);
        check("step_idle", 64'(busy), 64'd0);
        cyc(1);
        check("step_once", 64'(ena), 64'h0);

        // Stall into deadlock.
        mask = '0; run = 1'b1;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!deadlock && k < 100);
        check("dl_cycles", 64'(k), 64'd17);
        cyc(2);
        check("dl_hold", 64'(deadlock), 64'd1);
        run = 1'b0; clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("dl_clear", 64'(deadlock), 64'd0);
        check("dl_count", 64'(fire_count), 64'd15);

        // Reset during RUN after five fires.
        mask = 8'hFF; run = 1'b1;
        cyc(6);
        reset = 1'b1;
        cyc(1);
        check("rst_ena", 64'(ena), 64'h0);
        check("rst_count", 64'(fire_count), 64'h0);
        reset = 1'b0;
        cyc(2);
        check("rerun_idx", 64'(fired_idx), 64'd0);
        check("rerun_ena", 64'(ena), 64'h1);
        run = 1'b0;
        cyc(1);

        // Randomized regimes checked by the model.
        for (int r = 0; r < 100; r++) begin
            int regime;
            regime = int'($urandom_range(0, 3));
            for (int c = 0; c < 30; c++) begin
                run   = ($urandom_range(0, 7) != 0);
                step  = ($urandom_range(0, 5) == 0);
                mode  = 1'(($urandom));
                clear = ($urandom_range(0, 9) == 0);
                reset = ($urandom_range(0, 299) == 0);
                mask  = (regime == 0) ? '0 : N'($urandom);
                if (regime == 1 && $urandom_range(0, 3) != 0) mask = '0;
                cyc(1);
            end
        end
        reset = 1'b1; run = 1'b0; step = 1'b0; clear = 1'b0;
        cyc(1);
        reset = 1'b0;

`ifdef ENA_SCHEDULER_RANDOM_EN
        // Random mode: spread and repeatability.
        for (int p = 0; p < 2; p++) begin
            foreach (hist[i]) hist[i] = 0;
            diffs = 0;
            reset = 1'b1;
            cyc(1);
            reset = 1'b0; mode = 1'b1; mask = 8'hFF; run = 1'b1;
            cyc(1);
            for (int c = 0; c < 1000; c++) begin
                cyc(1);
                hist[fired_idx]++;
                if (p == 0) seq1[c] = fired_idx;
                else if (seq1[c] !== fired_idx) diffs++;
            end
            run = 1'b0;
            cyc(1);
            for (int i = 0; i < N; i++)
                check("rnd_spread", 64'(hist[i] >= 60), 64'd1);
            if (p == 1) check("rnd_repeat", 64'(diffs), 64'd0);
        end
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
